// File: rtl/csr_target_arbiter.sv
// csr_target_arbiter: round-robin arbiter that lets two CSR masters share one
// CSR target, one transaction at a time, with a watchdog that forces completion.
// Ports: clk, clk__enable (state qualifier), reset_n (sync, active low);
//   m0/m1_csr_request__* in, m0/m1_csr_response__* out (granted master only);
//   csr_request__* out and csr_response__* in (target side);
//   timeout_count out (saturating count of forced completions).
module csr_target_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES  = 1023,
  parameter logic [31:0] ERROR_READ_DATA = 32'hdead_dead
) (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset_n,

  input  logic        m0_csr_request__valid,
  input  logic        m0_csr_request__read_not_write,
  input  logic [15:0] m0_csr_request__select,
  input  logic [15:0] m0_csr_request__address,
  input  logic [31:0] m0_csr_request__data,
  output logic        m0_csr_response__acknowledge,
  output logic        m0_csr_response__read_data_valid,
  output logic        m0_csr_response__read_data_error,
  output logic [31:0] m0_csr_response__read_data,

  input  logic        m1_csr_request__valid,
  input  logic        m1_csr_request__read_not_write,
  input  logic [15:0] m1_csr_request__select,
  input  logic [15:0] m1_csr_request__address,
  input  logic [31:0] m1_csr_request__data,
  output logic        m1_csr_response__acknowledge,
  output logic        m1_csr_response__read_data_valid,
  output logic        m1_csr_response__read_data_error,
  output logic [31:0] m1_csr_response__read_data,

  output logic        csr_request__valid,
  output logic        csr_request__read_not_write,
  output logic [15:0] csr_request__select,
  output logic [15:0] csr_request__address,
  output logic [31:0] csr_request__data,
  input  logic        csr_response__acknowledge,
  input  logic        csr_response__read_data_valid,
  input  logic        csr_response__read_data_error,
  input  logic [31:0] csr_response__read_data,

  output logic [7:0]  timeout_count
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FORWARD   = 3'd1;
  localparam logic [2:0] ST_WAIT_READ = 3'd2;
  localparam logic [2:0] ST_TIMEOUT   = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;

  localparam logic [9:0] TIMEOUT_LIMIT = 10'(TIMEOUT_CYCLES);

  logic [2:0] state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       is_read_q, is_read_d;
  logic [9:0] counter_q, counter_d;
  logic [7:0] timeout_count_q, timeout_count_d;

  logic       g_valid;
  logic       g_rnw;
  logic [15:0] g_select;
  logic [15:0] g_address;
  logic [31:0] g_data;

  logic       pick;
  logic [9:0] counter_inc;

  logic        rsp_ack;
  logic        rsp_rdv;
  logic        rsp_err;
  logic [31:0] rsp_data;

  // Request fields of the granted master (grant_q: 0 = m0, 1 = m1).
  always_comb begin
    g_valid   = grant_q ? m1_csr_request__valid
                        : m0_csr_request__valid;
    g_rnw     = grant_q ? m1_csr_request__read_not_write
                        : m0_csr_request__read_not_write;
    g_select  = grant_q ? m1_csr_request__select
                        : m0_csr_request__select;
    g_address = grant_q ? m1_csr_request__address
                        : m0_csr_request__address;
    g_data    = grant_q ? m1_csr_request__data
                        : m0_csr_request__data;
  end

  // On contention the master that did not win last time is chosen.
  assign pick = (m0_csr_request__valid & m1_csr_request__valid)
              ? ~last_grant_q
              : ~m0_csr_request__valid;

  assign counter_inc = counter_q + 10'd1;

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    is_read_d       = is_read_q;
    counter_d       = counter_q;
    timeout_count_d = timeout_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_csr_request__valid | m1_csr_request__valid) begin
          grant_d      = pick;
          last_grant_d = pick;
          is_read_d    = pick ? m1_csr_request__read_not_write
                              : m0_csr_request__read_not_write;
          counter_d    = '0;
          state_d      = ST_FORWARD;
        end
      end
      ST_FORWARD: begin
        if (csr_response__acknowledge) begin
          if (!is_read_q || csr_response__read_data_valid) begin
            state_d = ST_DRAIN;
          end else begin
            counter_d = '0;
            state_d   = ST_WAIT_READ;
          end
        end else if (counter_inc == TIMEOUT_LIMIT) begin
          state_d = ST_TIMEOUT;
        end else begin
          counter_d = counter_inc;
        end
      end
      ST_WAIT_READ: begin
        if (csr_response__read_data_valid) begin
          state_d = ST_DRAIN;
        end else if (counter_inc == TIMEOUT_LIMIT) begin
          state_d = ST_TIMEOUT;
        end else begin
          counter_d = counter_inc;
        end
      end
      ST_TIMEOUT: begin
        if (timeout_count_q != 8'hff) begin
          timeout_count_d = timeout_count_q + 8'd1;
        end
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave only once the old acknowledge and request have both gone.
        if (!g_valid && !csr_response__acknowledge) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_request__valid          = 1'b0;
    csr_request__read_not_write = 1'b0;
    csr_request__select         = '0;
    csr_request__address        = '0;
    csr_request__data           = '0;
    rsp_ack  = 1'b0;
    rsp_rdv  = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;
    unique case (state_q)
      ST_FORWARD: begin
        csr_request__valid          = g_valid;
        csr_request__read_not_write = g_rnw;
        csr_request__select         = g_select;
        csr_request__address        = g_address;
        csr_request__data           = g_data;
        rsp_ack  = csr_response__acknowledge;
        rsp_rdv  = csr_response__read_data_valid;
        rsp_err  = csr_response__read_data_error;
        rsp_data = csr_response__read_data;
      end
      ST_WAIT_READ: begin
        rsp_rdv  = csr_response__read_data_valid;
        rsp_err  = csr_response__read_data_error;
        rsp_data = csr_response__read_data;
      end
      ST_TIMEOUT: begin
        rsp_ack = 1'b1;
        if (is_read_q) begin
          rsp_rdv  = 1'b1;
          rsp_err  = 1'b1;
          rsp_data = ERROR_READ_DATA;
        end
      end
      default: ;
    endcase
  end

  assign m0_csr_response__acknowledge     = rsp_ack & ~grant_q;
  assign m0_csr_response__read_data_valid = rsp_rdv & ~grant_q;
  assign m0_csr_response__read_data_error = rsp_err & ~grant_q;
  assign m0_csr_response__read_data       = grant_q ? '0 : rsp_data;

  assign m1_csr_response__acknowledge     = rsp_ack & grant_q;
  assign m1_csr_response__read_data_valid = rsp_rdv & grant_q;
  assign m1_csr_response__read_data_error = rsp_err & grant_q;
  assign m1_csr_response__read_data       = grant_q ? rsp_data : '0;

  assign timeout_count = timeout_count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      grant_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      is_read_q       <= 1'b0;
      counter_q       <= '0;
      timeout_count_q <= '0;
    end else if (clk__enable) begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      is_read_q       <= is_read_d;
      counter_q       <= counter_d;
      timeout_count_q <= timeout_count_d;
    end
  end

endmodule

// File: tb/tb_csr_target_arbiter.sv
// tb_csr_target_arbiter: directed stimulus with a queue-based scoreboard
// for csr_target_arbiter (TIMEOUT_CYCLES = 8).
module tb_csr_target_arbiter;

  typedef struct packed {
    logic        rd;
    logic [15:0] sel;
    logic [15:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct packed {
    logic        rd;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic clk__enable = 1'b1;
  logic reset_n = 1'b0;

  logic        m0_csr_request__valid = 1'b0;
  logic        m0_csr_request__read_not_write = 1'b0;
  logic [15:0] m0_csr_request__select = '0;
  logic [15:0] m0_csr_request__address = '0;
  logic [31:0] m0_csr_request__data = '0;
  logic        m0_csr_response__acknowledge;
  logic        m0_csr_response__read_data_valid;
  logic        m0_csr_response__read_data_error;
  logic [31:0] m0_csr_response__read_data;

  logic        m1_csr_request__valid = 1'b0;
  logic        m1_csr_request__read_not_write = 1'b0;
  logic [15:0] m1_csr_request__select = '0;
  logic [15:0] m1_csr_request__address = '0;
  logic [31:0] m1_csr_request__data = '0;
  logic        m1_csr_response__acknowledge;
  logic        m1_csr_response__read_data_valid;
  logic        m1_csr_response__read_data_error;
  logic [31:0] m1_csr_response__read_data;

  logic        csr_request__valid;
  logic        csr_request__read_not_write;
  logic [15:0] csr_request__select;
  logic [15:0] csr_request__address;
  logic [31:0] csr_request__data;
  logic        csr_response__acknowledge = 1'b0;
  logic        csr_response__read_data_valid = 1'b0;
  logic        csr_response__read_data_error = 1'b0;
  logic [31:0] csr_response__read_data = '0;

  logic [7:0]  timeout_count;

  req_t cq0[$];
  req_t cq1[$];
  req_t tq[$];
  rsp_t eq0[$];
  rsp_t eq1[$];

  int checks = 0;
  int failures = 0;

  bit mon_en = 1'b0;
  bit abort = 1'b0;
  bit busy0 = 1'b0;
  bit busy1 = 1'b0;
  bit a0 = 1'b0;
  bit a1 = 1'b0;
  bit tprev = 1'b0;

  int          tgt_ack_dly = 1;
  int          tgt_rd_dly = 0;
  bit          tgt_silent = 1'b0;
  logic [31:0] tgt_rdata = '0;

  always #5 clk = ~clk;

  csr_target_arbiter #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                              (clk),
    .clk__enable                      (clk__enable),
    .reset_n                          (reset_n),
    .m0_csr_request__valid            (m0_csr_request__valid),
    .m0_csr_request__read_not_write   (m0_csr_request__read_not_write),
    .m0_csr_request__select           (m0_csr_request__select),
    .m0_csr_request__address          (m0_csr_request__address),
    .m0_csr_request__data             (m0_csr_request__data),
    .m0_csr_response__acknowledge     (m0_csr_response__acknowledge),
    .m0_csr_response__read_data_valid (m0_csr_response__read_data_valid),
    .m0_csr_response__read_data_error (m0_csr_response__read_data_error),
    .m0_csr_response__read_data       (m0_csr_response__read_data),
    .m1_csr_request__valid            (m1_csr_request__valid),
    .m1_csr_request__read_not_write   (m1_csr_request__read_not_write),
    .m1_csr_request__select           (m1_csr_request__select),
    .m1_csr_request__address          (m1_csr_request__address),
    .m1_csr_request__data             (m1_csr_request__data),
    .m1_csr_response__acknowledge     (m1_csr_response__acknowledge),
    .m1_csr_response__read_data_valid (m1_csr_response__read_data_valid),
    .m1_csr_response__read_data_error (m1_csr_response__read_data_error),
    .m1_csr_response__read_data       (m1_csr_response__read_data),
    .csr_request__valid               (csr_request__valid),
    .csr_request__read_not_write      (csr_request__read_not_write),
    .csr_request__select              (csr_request__select),
    .csr_request__address             (csr_request__address),
    .csr_request__data                (csr_request__data),
    .csr_response__acknowledge        (csr_response__acknowledge),
    .csr_response__read_data_valid    (csr_response__read_data_valid),
    .csr_response__read_data_error    (csr_response__read_data_error),
    .csr_response__read_data          (csr_response__read_data),
    .timeout_count                    (timeout_count)
  );

  task automatic chk(input string nm,
                     input logic [79:0] got,
                     input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{m0_csr_response__acknowledge,
             m0_csr_response__read_data_valid,
             m0_csr_response__read_data_error,
             m0_csr_response__read_data,
             m1_csr_response__acknowledge,
             m1_csr_response__read_data_valid,
             m1_csr_response__read_data_error,
             m1_csr_response__read_data,
             csr_request__valid,
             csr_request__read_not_write,
             csr_request__select,
             csr_request__address,
             csr_request__data,
             timeout_count};
  endfunction

  task automatic issue(input int m, input req_t r, input rsp_t e);
    if (m == 0) begin
      cq0.push_back(r);
      eq0.push_back(e);
    end else begin
      cq1.push_back(r);
      eq1.push_back(e);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (cq0.size() == 0 && cq1.size() == 0 &&
          !busy0 && !busy1 &&
          eq0.size() == 0 && eq1.size() == 0 &&
          tq.size() == 0 && !csr_request__valid)
        break;
      n++;
    end
    if (n >= 200) chk({nm, "_done"}, 80'd0, 80'd1);
    repeat (3) @(negedge clk);
  endtask

  // Master drivers: one command at a time each, valid dropped after ack.
  initial begin
    req_t c;
    forever begin
      @(negedge clk);
      a0 = m0_csr_response__acknowledge;
      a1 = m1_csr_response__acknowledge;
      @(posedge clk);
      #1;
      if (busy0) begin
        if (a0 || abort) begin
          m0_csr_request__valid = 1'b0;
          busy0 = 1'b0;
        end
      end else if (!abort && cq0.size() > 0) begin
        c = cq0.pop_front();
        m0_csr_request__read_not_write = c.rd;
        m0_csr_request__select = c.sel;
        m0_csr_request__address = c.addr;
        m0_csr_request__data = c.data;
        m0_csr_request__valid = 1'b1;
        busy0 = 1'b1;
      end
      if (busy1) begin
        if (a1 || abort) begin
          m1_csr_request__valid = 1'b0;
          busy1 = 1'b0;
        end
      end else if (!abort && cq1.size() > 0) begin
        c = cq1.pop_front();
        m1_csr_request__read_not_write = c.rd;
        m1_csr_request__select = c.sel;
        m1_csr_request__address = c.addr;
        m1_csr_request__data = c.data;
        m1_csr_request__valid = 1'b1;
        busy1 = 1'b1;
      end
    end
  end

  // Target model: ack after tgt_ack_dly cycles, read data tgt_rd_dly later.
  initial begin
    bit rd;
    forever begin
      @(posedge clk);
      #1;
      if (csr_request__valid && !tgt_silent) begin
        rd = csr_request__read_not_write;
        repeat (tgt_ack_dly) begin
          @(posedge clk);
          #1;
        end
        csr_response__acknowledge = 1'b1;
        if (rd && tgt_rd_dly == 0) begin
          csr_response__read_data_valid = 1'b1;
          csr_response__read_data = tgt_rdata;
        end
        @(posedge clk);
        #1;
        csr_response__acknowledge = 1'b0;
        csr_response__read_data_valid = 1'b0;
        csr_response__read_data = '0;
        if (rd && tgt_rd_dly > 0) begin
          repeat (tgt_rd_dly - 1) begin
            @(posedge clk);
            #1;
          end
          csr_response__read_data_valid = 1'b1;
          csr_response__read_data = tgt_rdata;
          @(posedge clk);
          #1;
          csr_response__read_data_valid = 1'b0;
          csr_response__read_data = '0;
        end
      end
    end
  end

  task automatic mon_m(input int m, input logic ack, input logic rdv,
                       input logic err, input logic [31:0] rdata);
    rsp_t e;
    bit empty;
    empty = (m == 0) ? (eq0.size() == 0) : (eq1.size() == 0);
    if (empty) begin
      chk($sformatf("m%0d_idle_outs", m), {ack, rdv, err, rdata}, 80'd0);
    end else begin
      e = (m == 0) ? eq0[0] : eq1[0];
      if (e.rd ? rdv : ack) begin
        if (m == 0) void'(eq0.pop_front());
        else void'(eq1.pop_front());
        if (e.rd) begin
          chk($sformatf("m%0d_rdata", m), rdata, e.rdata);
          chk($sformatf("m%0d_rerr", m), err, e.err);
        end else begin
          chk($sformatf("m%0d_wr_rsp", m), {rdv, err}, 80'd0);
        end
      end
    end
  endtask

  // Scoreboard monitor.
  initial begin
    req_t t;
    req_t got;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        tprev = 1'b0;
        continue;
      end
      mon_m(0, m0_csr_response__acknowledge,
            m0_csr_response__read_data_valid,
            m0_csr_response__read_data_error,
            m0_csr_response__read_data);
      mon_m(1, m1_csr_response__acknowledge,
            m1_csr_response__read_data_valid,
            m1_csr_response__read_data_error,
            m1_csr_response__read_data);
      if (tprev) chk("drain_gap", csr_request__valid, 80'd0);
      tprev = csr_request__valid && csr_response__acknowledge;
      if (tprev) begin
        got = '{csr_request__read_not_write, csr_request__select,
                csr_request__address, csr_request__data};
        if (tq.size() == 0) begin
          chk("tgt_unexpected", got, 80'd0);
        end else begin
          t = tq.pop_front();
          chk("tgt_req", got, t);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req_t r;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", any_out(), 80'd0);
    reset_n = 1'b1;
    mon_en = 1'b1;

    // single write from m0, target acks after 2 cycles
    tgt_ack_dly = 2;
    r = '{1'b0, 16'd3, 16'h0010, 32'h1234_5678};
    tq.push_back(r);
    issue(0, r, '{1'b0, 1'b0, 32'h0});
    n = 0;
    while (!m0_csr_request__valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("m0_valid_seen", m0_csr_request__valid, 80'd1);
    chk("lat_idle", csr_request__valid, 80'd0);
    @(negedge clk);
    chk("lat_fwd", csr_request__valid, 80'd1);
    wait_idle("single_write");

    // m1 read, data three cycles after ack
    tgt_ack_dly = 1;
    tgt_rd_dly = 3;
    tgt_rdata = 32'hcafe_f00d;
    r = '{1'b1, 16'd1, 16'h0004, 32'h0};
    tq.push_back(r);
    issue(1, r, '{1'b1, 1'b0, 32'hcafe_f00d});
    wait_idle("delayed_read");
    tgt_rd_dly = 0;

    // contention: four writes each, expected strict alternation m0 first
    for (int i = 0; i < 4; i++) begin
      r = '{1'b0, 16'd0, 16'(16'h0100 + i), 32'(32'ha000_0000 + i)};
      issue(0, r, '{1'b0, 1'b0, 32'h0});
      tq.push_back(r);
      r = '{1'b0, 16'd2, 16'(16'h0200 + i), 32'(32'hb000_0000 + i)};
      issue(1, r, '{1'b0, 1'b0, 32'h0});
      tq.push_back(r);
    end
    wait_idle("contention");

    // timeout: target never answers an m0 read
    tgt_silent = 1'b1;
    issue(0, '{1'b1, 16'd1, 16'h0020, 32'h0}, '{1'b1, 1'b1, 32'hdead_dead});
    n = 0;
    while (!csr_request__valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (csr_request__valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("fwd_cycles", n, 80'd8);
    chk("to_ack", m0_csr_response__acknowledge, 80'd1);
    wait_idle("timeout");
    chk("timeout_count_1", timeout_count, 80'd1);
    tgt_silent = 1'b0;
    r = '{1'b0, 16'd5, 16'h0024, 32'h5555_aaaa};
    tq.push_back(r);
    issue(1, r, '{1'b0, 1'b0, 32'h0});
    wait_idle("after_timeout");
    chk("timeout_count_keep", timeout_count, 80'd1);

    // reset during WAIT_READ of an m0 read
    tgt_ack_dly = 1;
    tgt_rd_dly = 6;
    tgt_rdata = 32'h1111_2222;
    r = '{1'b1, 16'd1, 16'h0030, 32'h0};
    tq.push_back(r);
    issue(0, r, '{1'b1, 1'b0, 32'h1111_2222});
    n = 0;
    while (!m0_csr_response__acknowledge && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_ack_seen", m0_csr_response__acknowledge, 80'd1);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    abort = 1'b1;
    reset_n = 1'b0;
    eq0.delete();
    eq1.delete();
    tq.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midread_reset_outs", any_out(), 80'd0);
    chk("midread_reset_tc", timeout_count, 80'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    abort = 1'b0;
    mon_en = 1'b1;
    tgt_rd_dly = 0;
    r = '{1'b0, 16'd7, 16'h0044, 32'h0000_0044};
    issue(1, r, '{1'b0, 1'b0, 32'h0});
    r = '{1'b0, 16'd6, 16'h0040, 32'h0000_0040};
    issue(0, r, '{1'b0, 1'b0, 32'h0});
    tq.push_back(r);
    tq.push_back('{1'b0, 16'd7, 16'h0044, 32'h0000_0044});
    wait_idle("post_reset");

    // enable held low for 5 cycles while forwarding
    tgt_ack_dly = 8;
    r = '{1'b0, 16'd9, 16'h0050, 32'h0bad_cafe};
    tq.push_back(r);
    issue(0, r, '{1'b0, 1'b0, 32'h0});
    n = 0;
    while (!csr_request__valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    clk__enable = 1'b0;
    @(negedge clk);
    chk("en_low_fwd", {csr_request__valid, csr_request__address},
        {1'b1, 16'h0050});
    repeat (4) @(posedge clk);
    @(posedge clk);
    #1;
    clk__enable = 1'b1;
    wait_idle("enable_low");
    chk("en_no_timeout", timeout_count, 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
